// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Sequential 32-bit MULT/MULTU/DIV/DIVU unit with architectural
//            HI/LO registers. Uses one shift-add or restoring step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_operand_a,
    input  logic [31:0] i_operand_b,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_by_zero,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] C_LAST_ITER = 6'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [5:0]  r_count;
    logic [1:0]  r_op;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [31:0] r_a_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_last;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_CALC) && (r_count == C_LAST_ITER);

    // Signed ops work on magnitudes; 0x80000000 is its own magnitude as unsigned.
    assign w_signed = ~i_op[0];
    assign w_mag_a  = (w_signed && i_operand_a[31]) ? (~i_operand_a + 32'd1) : i_operand_a;
    assign w_mag_b  = (w_signed && i_operand_b[31]) ? (~i_operand_b + 32'd1) : i_operand_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_div_by_zero = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_CALC;
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (r_count == C_LAST_ITER) w_state_next = S_DONE;
            end
            S_DONE: begin
                o_done        = 1'b1;
                o_div_by_zero = r_div_zero;
                w_state_next  = w_accept ? S_CALC : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Multiply: {HI,LO} shifts right, multiplier in LO. Divide: {rem,quot} shifts left.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
        w_div_shift = r_acc[63:31];
        w_div_diff  = w_div_shift - {1'b0, r_mag_b};
        if (r_op[1]) begin
            if (w_div_diff[32]) begin
                w_acc_step = {w_div_shift[31:0], r_acc[30:0], 1'b0};
            end else begin
                w_acc_step = {w_div_diff[31:0], r_acc[30:0], 1'b1};
            end
        end else begin
            w_acc_step = {w_mul_sum, r_acc[31:1]};
        end
    end

    always_comb begin
        w_prod   = r_neg_q ? (~w_acc_step + 64'd1) : w_acc_step;
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_op[1]) begin
            if (r_div_zero) begin
                w_res_hi = r_a_raw;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_lo = r_neg_q ? (~w_acc_step[31:0] + 32'd1) : w_acc_step[31:0];
                w_res_hi = r_neg_r ? (~w_acc_step[63:32] + 32'd1) : w_acc_step[63:32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 6'd0;
            r_op       <= 2'd0;
            r_mag_a    <= 32'd0;
            r_mag_b    <= 32'd0;
            r_a_raw    <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= 64'd0;
        end else if (w_accept) begin
            r_count    <= 6'd0;
            r_op       <= i_op;
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            r_a_raw    <= i_operand_a;
            r_neg_q    <= w_signed && (i_operand_a[31] ^ i_operand_b[31]);
            r_neg_r    <= w_signed && i_operand_a[31];
            r_div_zero <= i_op[1] && (i_operand_b == 32'd0);
            r_acc      <= i_op[1] ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_step;
            if (!w_last) r_count <= r_count + 6'd1;
        end
    end

    // HI/LO: result on the final iteration edge, MTHI/MTLO only outside CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state != S_CALC) begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_hi_we;
    logic        i_lo_we;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = 32'd0;
    logic [31:0] exp_lo  = 32'd0;

    muldiv_seq dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_operand_a  (i_operand_a),
        .i_operand_b  (i_operand_b),
        .i_hi_we      (i_hi_we),
        .i_lo_we      (i_lo_we),
        .i_wdata      (i_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_div_by_zero(o_div_by_zero),
        .o_hi         (o_hi),
        .o_lo         (o_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic [63:0] p;
        longint      sp;
        int          sq;
        int          sr;
        dbz = 1'b0;
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = 64'(sp);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    dbz = 1'b1;
                    hi  = a;
                    lo  = 32'hFFFF_FFFF;
                end else if (op == 2'b11) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    lo = sq;
                    hi = sr;
                end
            end
        endcase
    endfunction

    // Issues one operation (entered #1 after an edge) and ends in the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit wr_lo,
                          input logic [31:0] wd);
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic        m_dbz;
        int          bad;
        model(op, a, b, m_hi, m_lo, m_dbz);
        i_start     = 1'b1;
        i_op        = op;
        i_operand_a = a;
        i_operand_b = b;
        if (wr_lo) begin
            i_lo_we = 1'b1;
            i_wdata = wd;
        end
        tick();
        if (wr_lo) exp_lo = wd;
        i_start     = 1'b0;
        i_lo_we     = 1'b0;
        i_op        = 2'($urandom_range(3, 0));
        i_operand_a = $urandom;
        i_operand_b = $urandom;
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_hi !== exp_hi || o_lo !== exp_lo) bad++;
            if (disturb && (c == 5 || c == 10)) i_start = 1'b1;
            if (disturb && c == 7) begin
                i_hi_we = 1'b1;
                i_wdata = 32'hDEAD_BEEF;
            end
            tick();
            i_start = 1'b0;
            i_hi_we = 1'b0;
        end
        check({tag, "_calc"}, 64'(bad), 64'd0);
        check({tag, "_done"}, {62'd0, o_done, o_busy}, 64'd2);
        check({tag, "_hi"}, {32'd0, o_hi}, {32'd0, m_hi});
        check({tag, "_lo"}, {32'd0, o_lo}, {32'd0, m_lo});
        check({tag, "_dbz"}, {63'd0, o_div_by_zero}, {63'd0, m_dbz});
        exp_hi = m_hi;
        exp_lo = m_lo;
    endtask

    task automatic idle_after_done(input string tag);
        tick();
        check({tag, "_pulse"}, {62'd0, o_done, o_busy}, 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [1:0]  r_op_v;
        logic [31:0] a_v;
        logic [31:0] b_v;

        reset       = 1'b1;
        i_start     = 1'b0;
        i_op        = 2'd0;
        i_operand_a = 32'd0;
        i_operand_b = 32'd0;
        i_hi_we     = 1'b0;
        i_lo_we     = 1'b0;
        i_wdata     = 32'd0;
        tick();
        tick();
        check("rst_hilo", {o_hi, o_lo}, 64'd0);
        check("rst_flags", {61'd0, o_busy, o_done, o_div_by_zero}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0, 32'd0);
        idle_after_done("mult_neg");
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        idle_after_done("multu_max");
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 32'd0);
        idle_after_done("div_neg");
        run_op("divu_zero", 2'b11, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
        idle_after_done("divu_zero");
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        idle_after_done("div_ovf");
        run_op("div_zero_s", 2'b10, 32'h8000_0005, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
        idle_after_done("div_zero_s");

        // MTLO, then starts and MTHI injected mid-calculation must be ignored.
        i_lo_we = 1'b1;
        i_wdata = 32'h1234_5678;
        tick();
        i_lo_we = 1'b0;
        exp_lo  = 32'h1234_5678;
        check("mtlo", {32'd0, o_lo}, 64'h1234_5678);
        run_op("disturb", 2'b01, 32'h0001_0003, 32'h0000_0100, 1'b1, 1'b0, 32'd0);
        idle_after_done("disturb");

        // Write and start in the same cycle; back-to-back start from DONE.
        run_op("wr_start", 2'b11, 32'd100, 32'd7, 1'b0, 1'b1, 32'hCAFE_0001);
        run_op("b2b", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        idle_after_done("b2b");

        for (int k = 0; k < 24; k++) begin
            r_op_v = 2'($urandom_range(3, 0));
            a_v    = $urandom;
            b_v    = $urandom;
            if ($urandom_range(7, 0) == 0) b_v = 32'd0;
            else if ($urandom_range(3, 0) == 0) b_v = 32'($urandom_range(15, 1));
            if ($urandom_range(3, 0) == 0) b_v = -b_v;
            run_op("rand", r_op_v, a_v, b_v, 1'b0, 1'b0, 32'd0);
            if ($urandom_range(1, 0) == 0) idle_after_done("rand");
        end
        tick();

        // Both write enables in one cycle.
        i_hi_we = 1'b1;
        i_lo_we = 1'b1;
        i_wdata = 32'h5A5A_A5A5;
        tick();
        i_hi_we = 1'b0;
        i_lo_we = 1'b0;
        check("mt_both", {o_hi, o_lo}, 64'h5A5A_A5A5_5A5A_A5A5);

        // Reset during CALC aborts the operation.
        i_start     = 1'b1;
        i_op        = 2'b01;
        i_operand_a = 32'h0000_1234;
        i_operand_b = 32'h0000_5678;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        check("pre_rst_busy", {63'd0, o_busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, o_busy}, 64'd0);
        check("abort_hilo", {o_hi, o_lo}, 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done !== 1'b0 || o_busy !== 1'b0) done_seen++;
            tick();
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Reset wins over start and writes in the same cycle.
        i_hi_we = 1'b1;
        i_lo_we = 1'b1;
        i_wdata = 32'hAAAA_5555;
        i_start = 1'b1;
        reset   = 1'b1;
        tick();
        i_hi_we = 1'b0;
        i_lo_we = 1'b0;
        i_start = 1'b0;
        reset   = 1'b0;
        check("rst_prio_hilo", {o_hi, o_lo}, 64'd0);
        tick();
        check("rst_prio_busy", {62'd0, o_busy, o_done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk is the clock and port reset is the reset.
REQ-002 clk  input  1  rising-edge clock shared with the EX pipeline stage.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 i_start  input  1  request a multiply/divide operation; sampled only when the block is not busy.
REQ-005 i_op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 i_operand_a  input  32  rs value: multiplicand or dividend.
REQ-007 i_operand_b  input  32  rt value: multiplier or divisor.
REQ-008 i_hi_we  input  1  MTHI write enable.
REQ-009 i_lo_we  input  1  MTLO write enable.
REQ-010 i_wdata  input  32  MTHI/MTLO write data.
REQ-011 o_busy  output  1  operation in progress; the pipeline stalls any MFHI/MFLO/MULT/DIV while it is 1.
REQ-012 o_done  output  1  one-cycle pulse signalling that HI/LO hold a new result.
REQ-013 o_div_by_zero  output  1  asserted together with o_done when a DIV/DIVU had divisor 0.
REQ-014 o_hi  output  32  architectural HI register.
REQ-015 o_lo  output  32  architectural LO register.

Function
REQ-016 States SHALL be IDLE, CALC and DONE: IDLE->CALC on an accepted start; CALC->DONE after exactly 32 iterations; DONE->IDLE, or DONE->CALC if a start is accepted in DONE.
REQ-017 A start SHALL be accepted on a rising edge where i_start=1 and the state is IDLE or DONE; at acceptance, i_op, the operand magnitudes and the result signs SHALL be latched internally.
REQ-018 i_start SHALL be ignored while in CALC, and the latched operands SHALL NOT change then.
REQ-019 o_busy SHALL be 1 exactly while in CALC: 32 cycles, starting the cycle after the accepting edge.
REQ-020 o_done SHALL be 1 exactly while in DONE (one cycle); o_busy SHALL be 0 in DONE.
REQ-021 Latency SHALL be 33 cycles from the accepting edge to o_done high.
REQ-022 Multiply SHALL use one shift-add iteration per CALC cycle on the 32-bit magnitudes, giving a 64-bit product with {HI,LO} = product.
REQ-023 For MULT, the product SHALL be two's-complement negated when exactly one operand is negative; MULTU SHALL treat both operands as unsigned.
REQ-024 Divide SHALL use one restoring-division step per CALC cycle: LO = quotient, HI = remainder.
REQ-025 For DIV, the quotient sign SHALL be a[31]^b[31] and the remainder sign SHALL be a[31]; DIVU SHALL be unsigned.
REQ-026 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no error flag.
REQ-027 Divide by zero (b=0) SHALL still take 32 cycles and SHALL give HI=i_operand_a as latched and LO=0xFFFFFFFF, with o_div_by_zero=1 during DONE.
REQ-028 o_hi/o_lo SHALL keep their previous values throughout CALC, with no partial results visible; both SHALL be updated on the CALC->DONE edge.
REQ-029 In IDLE or DONE, i_hi_we/i_lo_we SHALL write i_wdata to HI/LO on the clock edge; writes during CALC SHALL be dropped.
REQ-030 If i_hi_we/i_lo_we and i_start are both sampled in IDLE/DONE, the write SHALL take effect and the operation SHALL still start; the result later overwrites both registers.
REQ-031 If i_hi_we and i_lo_we are both 1 in the same cycle, both registers SHALL receive i_wdata.
REQ-032 The iteration counter SHALL be 6 bits, count 0..31, and not wrap into a 33rd iteration.

Reset
REQ-033 While reset=1 on an edge, the block SHALL enter IDLE with o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0 and the internal counter and accumulators cleared.
REQ-034 A reset during CALC SHALL abort the operation: no o_done pulse follows, and HI/LO are 0.
REQ-035 Reset SHALL take priority over i_start and over HI/LO writes in the same cycle.

Verification
REQ-036 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> o_busy high 32 cycles; o_done on cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF, o_div_by_zero=1 with o_done.
REQ-039 MTLO 0x12345678, then i_start pulsed on cycles 5 and 10 of CALC -> both extra starts ignored; LO unchanged until DONE; MTHI issued during CALC is dropped.
REQ-040 Reset asserted on cycle 16 of CALC -> next cycle o_busy=0, HI=LO=0, and no o_done for the next 40 cycles.
REQ-041 Back-to-back start asserted in DONE -> o_done pulses once, then o_busy=1 the next cycle, and the second result appears 33 cycles after the second accepting edge.
